split_module_6bit: RTL and testbench
====================================

SPLIT_MODULE_6BIT -- requirements
Module: split_module_6bit

Interface
REQ-001: Parameter n, default 6: full operand width; SHALL be even.
REQ-002: Parameter h, default n/2 (3): half-operand width.
REQ-003: clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: in_valid  input  1  operand pair A_in/B_in presented.
REQ-006: in_ready  output  1  block can accept an operand pair.
REQ-007: A_in  input  n  operand A, polynomial over GF(2).
REQ-008: B_in  input  n  operand B, polynomial over GF(2).
REQ-009: S_valid  output  1  sub-operand pair on S_a/S_b is valid.
REQ-010: S_ready  input  1  downstream h-bit sub-multiplier accepts the pair.
REQ-011: S_a  output  h  sub-operand from A.
REQ-012: S_b  output  h  sub-operand from B.
REQ-013: S_sel  output  2  tag: 1=lo (feeds B2_in1), 2=mid (feeds B2_in2), 3=hi (feeds B2_in3), 0=none.
REQ-014: S_last  output  1  high with the final (hi) pair of an operation.
REQ-015: op_count  output  8  number of completed operations, modulo 256.

Function
REQ-016: Split: lo = X[h-1:0], hi = X[n-1:h], mid = lo XOR hi, for X in {A, B}; no carries anywhere.
REQ-017: FSM states: IDLE, ISSUE_LO, ISSUE_MID, ISSUE_HI.
REQ-018: in_ready SHALL be 1 exactly in IDLE, combinationally from state.
REQ-019: IDLE with in_valid=1: A_in, B_in SHALL be registered, next state ISSUE_LO; IDLE with in_valid=0: stay.
REQ-020: S_a, S_b, S_sel, S_valid, S_last SHALL be registered outputs; first pair SHALL appear the cycle after acceptance (latency 1).
REQ-021: ISSUE_LO drives lo pair, S_sel=1; ISSUE_MID drives mid pair, S_sel=2; ISSUE_HI drives hi pair, S_sel=3, S_last=1.
REQ-022: S_valid SHALL be 1 in every ISSUE_* state and 0 in IDLE.
REQ-023: Advance LO->MID->HI->IDLE only on the cycle S_valid and S_ready are both 1.
REQ-024: While S_ready=0, S_a, S_b, S_sel, S_last SHALL hold stable.
REQ-025: Handshake in ISSUE_HI SHALL increment op_count by 1, wrapping 255->0.
REQ-026: in_ready is 0 during the HI handshake cycle; a new operand pair is accepted no earlier than the following cycle (minimum 4 cycles per operation).
REQ-027: in_valid and operand changes outside IDLE SHALL be ignored; captured operands stay fixed until return to IDLE.
REQ-028: In IDLE, S_sel=0, S_last=0; S_a and S_b hold their last values.

Reset
REQ-029: rst_n=0 SHALL immediately force IDLE, S_valid=0, S_sel=0, S_last=0, S_a=0, S_b=0, op_count=0, captured operands=0, regardless of clk.
REQ-030: Reset asserted mid-operation SHALL abandon the operation with no further pairs issued and op_count not incremented; after release, in_ready=1 on the first cycle.

Verification
REQ-031: A_in=6'b101110, B_in=6'b011001, S_ready=1 -> pairs (110,001,sel1), (011,010,sel2), (101,011,sel3, S_last=1) on 3 consecutive cycles; op_count=1.
REQ-032: Same operands, S_ready=0 for 5 cycles after first S_valid -> lo pair held stable for 5 cycles; in_ready=0; ordering then as in REQ-031.
REQ-033: A_in=6'b111111, B_in=6'b000000 -> mid pair (000,000); A_in=6'b000111 -> mid A=111.
REQ-034: 256 back-to-back operations with in_valid=1 and S_ready=1 -> op_count wraps to 0; each operation takes exactly 4 cycles from acceptance to next acceptance.
REQ-035: rst_n pulsed low in ISSUE_MID -> S_valid=0 immediately, op_count unchanged at 0, in_ready=1 after release; next operation issues from lo.
REQ-036: A_in changed while in ISSUE_LO -> issued mid/hi pairs SHALL derive from the originally captured A_in.

Source files
------------

// File: rtl/split_module_6bit.sv
// Operand splitter for a one-level GF(2) Karatsuba multiplier: captures an A/B pair
// and issues the lo, mid (lo^hi) and hi sub-operand pairs over a valid/ready handshake.
module split_module_6bit #(
   parameter int n = 6,
   parameter int h = n / 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [n-1:0] A_in,
   input  logic [n-1:0] B_in,
   output logic         S_valid,
   input  logic         S_ready,
   output logic [h-1:0] S_a,
   output logic [h-1:0] S_b,
   output logic [1:0]   S_sel,
   output logic         S_last,
   output logic [7:0]   op_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE_LO  = 2'd1,
      ISSUE_MID = 2'd2,
      ISSUE_HI  = 2'd3
   } state_t;

   state_t       r_state, w_state;
   logic [n-1:0] r_a, r_b, w_a, w_b;
   logic [h-1:0] r_sa, r_sb, w_sa, w_sb;
   logic [1:0]   r_sel, w_sel;
   logic         r_last, w_last;
   logic         r_valid, w_valid;
   logic [7:0]   r_count, w_count;

   function automatic logic [h-1:0] f_lo(input logic [n-1:0] x);
      return x[h-1:0];
   endfunction

   function automatic logic [h-1:0] f_hi(input logic [n-1:0] x);
      return x[h +: h];
   endfunction

   function automatic logic [h-1:0] f_mid(input logic [n-1:0] x);
      return f_lo(x) ^ f_hi(x);
   endfunction

   assign in_ready = (r_state == IDLE);
   assign S_valid  = r_valid;
   assign S_a      = r_sa;
   assign S_b      = r_sb;
   assign S_sel    = r_sel;
   assign S_last   = r_last;
   assign op_count = r_count;

   // Next-state and next-output decode; outputs are precomputed so they leave a register.
   always_comb begin
      w_state = r_state;
      w_a     = r_a;
      w_b     = r_b;
      w_sa    = r_sa;
      w_sb    = r_sb;
      w_sel   = r_sel;
      w_last  = r_last;
      w_valid = r_valid;
      w_count = r_count;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_state = ISSUE_LO;
               w_a     = A_in;
               w_b     = B_in;
               w_sa    = f_lo(A_in);
               w_sb    = f_lo(B_in);
               w_sel   = 2'd1;
               w_last  = 1'b0;
               w_valid = 1'b1;
            end else begin
               w_state = IDLE;
            end
         end
         ISSUE_LO: begin
            if (S_ready) begin
               w_state = ISSUE_MID;
               w_sa    = f_mid(r_a);
               w_sb    = f_mid(r_b);
               w_sel   = 2'd2;
            end else begin
               w_state = ISSUE_LO;
            end
         end
         ISSUE_MID: begin
            if (S_ready) begin
               w_state = ISSUE_HI;
               w_sa    = f_hi(r_a);
               w_sb    = f_hi(r_b);
               w_sel   = 2'd3;
               w_last  = 1'b1;
            end else begin
               w_state = ISSUE_MID;
            end
         end
         ISSUE_HI: begin
            if (S_ready) begin
               // S_a/S_b keep the hi pair while idle.
               w_state = IDLE;
               w_sel   = 2'd0;
               w_last  = 1'b0;
               w_valid = 1'b0;
               w_count = r_count + 8'd1;
            end else begin
               w_state = ISSUE_HI;
            end
         end
         default: begin
            w_state = IDLE;
            w_sel   = 2'd0;
            w_last  = 1'b0;
            w_valid = 1'b0;
         end
      endcase
   end

   // State, captured operands and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sa    <= '0;
         r_sb    <= '0;
         r_sel   <= 2'd0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
         r_count <= 8'd0;
      end else begin
         r_state <= w_state;
         r_a     <= w_a;
         r_b     <= w_b;
         r_sa    <= w_sa;
         r_sb    <= w_sb;
         r_sel   <= w_sel;
         r_last  <= w_last;
         r_valid <= w_valid;
         r_count <= w_count;
      end
   end

endmodule

// File: tb/tb_split_module_6bit.sv
// Directed bench for split_module_6bit: inputs change and outputs are sampled on the falling edge.
module tb_split_module_6bit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] A_in, B_in;
   logic       S_valid;
   logic       S_ready;
   logic [2:0] S_a, S_b;
   logic [1:0] S_sel;
   logic       S_last;
   logic [7:0] op_count;

   int errs   = 0;
   int checks = 0;

   split_module_6bit dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A_in(A_in), .B_in(B_in), .S_valid(S_valid), .S_ready(S_ready),
      .S_a(S_a), .S_b(S_b), .S_sel(S_sel), .S_last(S_last), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_pair(input string tag, input logic [2:0] a, input logic [2:0] b,
                           input logic [1:0] sel, input logic last);
      chk({tag, ".valid"}, 32'(S_valid), 32'(1'b1));
      chk({tag, ".a"},     32'(S_a),     32'(a));
      chk({tag, ".b"},     32'(S_b),     32'(b));
      chk({tag, ".sel"},   32'(S_sel),   32'(sel));
      chk({tag, ".last"},  32'(S_last),  32'(last));
      chk({tag, ".rdy"},   32'(in_ready), 32'(1'b0));
   endtask

   task automatic chk_idle(input string tag, input logic [2:0] a, input logic [2:0] b,
                           input logic [7:0] cnt);
      chk({tag, ".valid"}, 32'(S_valid),  32'(1'b0));
      chk({tag, ".sel"},   32'(S_sel),    32'(2'd0));
      chk({tag, ".last"},  32'(S_last),   32'(1'b0));
      chk({tag, ".a"},     32'(S_a),      32'(a));
      chk({tag, ".b"},     32'(S_b),      32'(b));
      chk({tag, ".rdy"},   32'(in_ready), 32'(1'b1));
      chk({tag, ".cnt"},   32'(op_count), 32'(cnt));
   endtask

   task automatic start(input logic [5:0] a, input logic [5:0] b, input logic rdy);
      A_in = a; B_in = b; in_valid = 1'b1; S_ready = rdy;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; S_ready = 1'b1; A_in = 6'd0; B_in = 6'd0;
      #12;
      chk_idle("reset", 3'b000, 3'b000, 8'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Basic operation: 101110 x 011001
      start(6'b101110, 6'b011001, 1'b1);
      chk_pair("op1.lo", 3'b110, 3'b001, 2'd1, 1'b0);
      @(negedge clk); chk_pair("op1.mid", 3'b011, 3'b010, 2'd2, 1'b0);
      @(negedge clk); chk_pair("op1.hi",  3'b101, 3'b011, 2'd3, 1'b1);
      @(negedge clk); chk_idle("op1.end", 3'b101, 3'b011, 8'd1);

      // Backpressure on the lo pair for 5 cycles
      start(6'b101110, 6'b011001, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk_pair("stall.lo", 3'b110, 3'b001, 2'd1, 1'b0);
         if (i < 4) @(negedge clk);
      end
      S_ready = 1'b1;
      @(negedge clk); chk_pair("stall.mid", 3'b011, 3'b010, 2'd2, 1'b0);
      @(negedge clk); chk_pair("stall.hi",  3'b101, 3'b011, 2'd3, 1'b1);
      @(negedge clk); chk_idle("stall.end", 3'b101, 3'b011, 8'd2);

      // Mid-pair corner cases
      start(6'b111111, 6'b000000, 1'b1);
      chk_pair("ones.lo", 3'b111, 3'b000, 2'd1, 1'b0);
      @(negedge clk); chk_pair("ones.mid", 3'b000, 3'b000, 2'd2, 1'b0);
      @(negedge clk); chk_pair("ones.hi",  3'b111, 3'b000, 2'd3, 1'b1);
      @(negedge clk); chk_idle("ones.end", 3'b111, 3'b000, 8'd3);
      start(6'b000111, 6'b000000, 1'b1);
      chk_pair("low.lo", 3'b111, 3'b000, 2'd1, 1'b0);
      @(negedge clk); chk_pair("low.mid", 3'b111, 3'b000, 2'd2, 1'b0);
      @(negedge clk); chk_pair("low.hi",  3'b000, 3'b000, 2'd3, 1'b1);
      @(negedge clk); chk_idle("low.end", 3'b000, 3'b000, 8'd4);

      // Operand and in_valid changes after capture are ignored
      start(6'b101110, 6'b011001, 1'b0);
      in_valid = 1'b1; A_in = 6'b000000; B_in = 6'b111111;
      chk_pair("chg.lo0", 3'b110, 3'b001, 2'd1, 1'b0);
      @(negedge clk); chk_pair("chg.lo1", 3'b110, 3'b001, 2'd1, 1'b0);
      S_ready = 1'b1;
      @(negedge clk); chk_pair("chg.mid", 3'b011, 3'b010, 2'd2, 1'b0);
      in_valid = 1'b0;
      @(negedge clk); chk_pair("chg.hi",  3'b101, 3'b011, 2'd3, 1'b1);
      @(negedge clk); chk_idle("chg.end", 3'b101, 3'b011, 8'd5);

      // Reset pulse while the mid pair is on the bus
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      start(6'b101110, 6'b011001, 1'b1);
      @(negedge clk); chk_pair("rst.mid", 3'b011, 3'b010, 2'd2, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_idle("rst.async", 3'b000, 3'b000, 8'd0);
      @(negedge clk); rst_n = 1'b1;
      chk_idle("rst.rel", 3'b000, 3'b000, 8'd0);
      @(negedge clk); chk_idle("rst.quiet", 3'b000, 3'b000, 8'd0);
      start(6'b101110, 6'b011001, 1'b1);
      chk_pair("rst.lo", 3'b110, 3'b001, 2'd1, 1'b0);
      @(negedge clk); chk_pair("rst.mid2", 3'b011, 3'b010, 2'd2, 1'b0);
      @(negedge clk); chk_pair("rst.hi",   3'b101, 3'b011, 2'd3, 1'b1);
      @(negedge clk); chk_idle("rst.end",  3'b101, 3'b011, 8'd1);

      // 256 back-to-back operations from a fresh reset
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      A_in = 6'b101110; B_in = 6'b011001; in_valid = 1'b1; S_ready = 1'b1;
      for (int k = 0; k < 1024; k++) begin
         chk("b2b.rdy", 32'(in_ready), 32'((k % 4) == 0));
         chk("b2b.sel", 32'(S_sel),    32'(k % 4));
         if ((k % 4) == 0) chk("b2b.cnt", 32'(op_count), 32'((k / 4) % 256));
         @(negedge clk);
      end
      chk("b2b.wrap", 32'(op_count), 32'(8'd0));
      chk("b2b.rdy_end", 32'(in_ready), 32'(1'b1));
      in_valid = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
